muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Sequential multiply/divide unit in the execute stage, beside the ALU.
- Takes the same two 32-bit operands the ALU receives.
- Runs MULT, MULTU, DIV and DIVU over multiple cycles and holds results in architectural HI/LO registers, which feed MFHI/MFLO back to the datapath.
- Also accepts MTHI/MTLO writes; hazard logic uses `busy` to stall dependent instructions.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch operation selected by `op`
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `inp_a`  in  32  multiplicand / dividend
- `inp_b`  in  32  multiplier / divisor
- `wr_hi`, `wr_lo`  in  1 each  MTHI / MTLO write enables
- `wr_data`  in  32  data for MTHI/MTLO
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: HI/LO hold new result
- `div_zero`  out  1  valid with `done`: last DIV/DIVU had `inp_b`==0
- `hi`, `lo`  out  32  architectural HI/LO

## Operation

FSM states: IDLE, RUN, FIX.
- **IDLE:**
  - `start`=1 latches `op`, `inp_a` and `inp_b`.
  - Signed ops convert operands to magnitudes and record the result signs.
  - Clears the 6-bit iteration counter, then goes to RUN.
  - Exception: DIV/DIVU with `inp_b`==0 stays in IDLE, leaves HI/LO unchanged and pulses `done`+`div_zero` next cycle.
- **RUN:** one radix-2 step per cycle, 32 steps; counter 0..31, leaves RUN when counter==31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring division, 32-bit remainder and quotient.
- **FIX:**
  - Applies sign correction and writes HI/LO, then returns to IDLE.
  - Multiply: {HI,LO} = 64-bit product, two's complement for signed.
  - Divide: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0, no flag.
- **Other rules:**
  - `start` while `busy`=1 is ignored.
  - `wr_hi`/`wr_lo` while `busy`=1 are ignored. In IDLE they write on the same edge; `wr_hi` and `wr_lo` together write both.
  - `start` and `wr_*` in the same IDLE cycle: start wins, writes dropped.
  - `div_zero` is 0 on every `done` except the divide-by-zero case; it is only meaningful while `done`=1.

## Timing

- **Reset values:** `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, state=IDLE.
- **Reset mid-operation:** aborts; the next cycle shows reset values and no `done`.
- **Normal op, `start` sampled at end of cycle 0:**
  - Cycles 1–32: RUN, `busy`=1.
  - Cycle 33: FIX, `busy`=1.
  - Cycle 34: `done`=1, `busy`=0, HI/LO valid. Latency 34 cycles.
- **Divide by zero:** `done`=`div_zero`=1 in cycle 1; `busy` stays 0.
- **Back-to-back:** a new `start` is accepted in the `done` cycle; the previous HI/LO stay visible until that op's FIX edge.
- **Output stability:** `hi`/`lo` are registered and change only at the FIX edge, an accepted write, or reset.

## Structure

- **Shared package `mips_pkg`:**
  - op-code localparams: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`
  - FSM state encodings: `MD_IDLE`, `MD_RUN`, `MD_FIX`
  - `MD_ITER`=32
- **Sub-module `abs_neg32`:** combinational conditional two's-complement. Used for operand magnitudes on entry and for result correction in FIX.
- Everything else lives in `muldiv_unit`.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> cycle 34: `done`=1, HI=0xFFFFFFFE, LO=0x00000001; `busy`=1 in cycles 1–33 only.
- MULT -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 after MTHI 0x1234 and MTLO 0x5678 -> cycle 1: `done`=`div_zero`=1, HI=0x1234, LO=0x5678.
- MULT running -> `start`, `wr_hi` and `wr_lo` pulsed at cycle 10 are ignored. Result matches a clean run and HI/LO are not overwritten by `wr_data`.
- `rst` at cycle 12 of a DIV -> cycle 13: `busy`=0, HI=LO=0, no `done` ever. A new MULTU 3×5 started afterwards gives LO=15, HI=0 at latency 34.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: mul/div op-codes, FSM states, iteration count.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    localparam int MD_ITER = 32;

    // Signed variants are the even op-codes.
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/abs_neg32.sv
// Conditional two's complement: dout = neg ? ~din + cin : din (cin chains a 64-bit negate).
// Latency: combinational.
// Backpressure: none.
module abs_neg32 (
    input  logic [31:0] din,
    input  logic        neg,
    input  logic        cin,
    output logic [31:0] dout
);

    always_comb begin
        dout = neg ? (~din + {31'd0, cin}) : din;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Sequential MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes.
// Latency: 34 cycles start-to-done (32 radix-2 steps + sign fix); divide-by-zero reports in 1.
// Backpressure: start and wr_hi/wr_lo are dropped while busy; no other flow control.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST_STEP = 6'(MD_ITER - 1);

    md_state_e   state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div_zero_q, div_zero_d;

    logic        sgn_in;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_trial, div_diff;
    logic [63:0] step_mul, step_div;
    logic        fix_hi_cin;
    logic [31:0] fix_hi, fix_lo;

    assign sgn_in = md_is_signed(op);

    abs_neg32 u_abs_a (.din(inp_a), .neg(sgn_in & inp_a[31]), .cin(1'b1), .dout(a_mag));
    abs_neg32 u_abs_b (.din(inp_b), .neg(sgn_in & inp_b[31]), .cin(1'b1), .dout(b_mag));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvsr_q} : 33'd0);
    assign step_mul = {mul_sum, acc_q[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
    assign div_trial = {acc_q[63:32], acc_q[31]};
    assign div_diff  = div_trial - {1'b0, dvsr_q};
    assign step_div  = div_diff[32] ? {div_trial[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0],  acc_q[30:0], 1'b1};

    // A 64-bit product negate needs the carry out of the low word into the high word.
    assign fix_hi_cin = op_q[1] ? 1'b1 : (acc_q[31:0] == 32'd0);

    abs_neg32 u_fix_hi (.din(acc_q[63:32]), .neg(op_q[1] ? neg_rem_q : neg_res_q),
                        .cin(fix_hi_cin), .dout(fix_hi));
    abs_neg32 u_fix_lo (.din(acc_q[31:0]), .neg(neg_res_q), .cin(1'b1), .dout(fix_lo));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dvsr_d     = dvsr_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    if (op[1] && (inp_b == 32'd0)) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        op_d      = op;
                        cnt_d     = 6'd0;
                        dvsr_d    = op[1] ? b_mag : a_mag;
                        acc_d     = {32'd0, op[1] ? a_mag : b_mag};
                        neg_res_d = sgn_in & (inp_a[31] ^ inp_b[31]);
                        neg_rem_d = sgn_in & inp_a[31];
                        busy_d    = 1'b1;
                        state_d   = MD_RUN;
                    end
                end else begin
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            MD_RUN: begin
                acc_d = op_q[1] ? step_div : step_mul;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) state_d = MD_FIX;
            end
            MD_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = MD_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MD_IDLE;
            op_q       <= MD_MULT;
            cnt_q      <= 6'd0;
            acc_q      <= 64'd0;
            dvsr_q     <= 32'd0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dvsr_q     <= dvsr_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes arithmetic results, a negedge monitor
// checks done timing, HI/LO, div_zero, busy window and MTHI/MTLO behaviour every cycle.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] inp_a, inp_b;
    logic        wr_hi, wr_lo;
    logic [31:0] wr_data;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          busy_lo = 1;
    int          busy_hi = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;
    exp_t        sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .inp_a(inp_a), .inp_b(inp_b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference arithmetic straight from the MIPS definitions.
    task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo, output logic dz);
        longint      sa, sb_, q, r;
        logic [63:0] p;
        dz  = 1'b0;
        rhi = 32'd0;
        rlo = 32'd0;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (o)
            OP_MULT:  begin p = 64'(sa * sb_);              rhi = p[63:32]; rlo = p[31:0]; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b};    rhi = p[63:32]; rlo = p[31:0]; end
            OP_DIV: begin
                if (b == 32'd0) dz = 1'b1;
                else begin
                    q = sa / sb_; r = sa % sb_;
                    p = 64'(q); rlo = p[31:0];
                    p = 64'(r); rhi = p[31:0];
                end
            end
            default: begin
                if (b == 32'd0) dz = 1'b1;
                else begin rlo = a / b; rhi = a % b; end
            end
        endcase
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic eb;
        eb = (cyc >= busy_lo) && (cyc <= busy_hi);
        chk("busy", {31'd0, busy}, {31'd0, eb});
        if (done) begin
            if (sb.size() == 0) begin
                n_vec = n_vec + 1;
                n_bad = n_bad + 1;
                $display("FAIL unexpected_done @cycle %0d: got done=1 expected done=0", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.due));
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                if (!e.dz) begin
                    mhi = e.hi;
                    mlo = e.lo;
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL done_timeout @cycle %0d: got no done expected done at cycle %0d",
                     cyc, sb[0].due);
            void'(sb.pop_front());
        end
        chk("hi", hi, mhi);
        chk("lo", lo, mlo);
        if (rst) begin
            mhi = 32'd0;
            mlo = 32'd0;
            sb.delete();
            if (busy_hi > cyc) busy_hi = cyc;
        end else if (!eb && !start) begin
            if (wr_hi) mhi = wr_data;
            if (wr_lo) mlo = wr_data;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic wh, input logic wl, input logic [31:0] wd,
                         output int due);
        exp_t e;
        ref_op(o, a, b, e.hi, e.lo, e.dz);
        e.due   = e.dz ? cyc + 1 : cyc + 34;
        due     = e.due;
        start   = 1'b1;
        op      = o;
        inp_a   = a;
        inp_b   = b;
        wr_hi   = wh;
        wr_lo   = wl;
        wr_data = wd;
        if (!e.dz) begin
            busy_lo = cyc + 1;
            busy_hi = cyc + 33;
        end
        sb.push_back(e);
        next_cycle();
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
    endtask

    task automatic mt(input logic wh, input logic wl, input logic [31:0] wd);
        wr_hi   = wh;
        wr_lo   = wl;
        wr_data = wd;
        next_cycle();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sb.size() != 0; i++) next_cycle();
        if (sb.size() != 0) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL wait_done: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        next_cycle();
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int due;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; op = 2'b00; inp_a = 32'd0; inp_b = 32'd0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'd0;
        repeat (3) next_cycle();
        rst = 1'b0;
        next_cycle();

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, due); wait_done();
        issue(OP_MULT,  -32'd3, 32'd7, 0, 0, 0, due);                wait_done();
        issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, 0, due); wait_done();
        issue(OP_DIV,   -32'd7, 32'd2, 0, 0, 0, due);                wait_done();
        issue(OP_DIVU,  32'd7, 32'd2, 0, 0, 0, due);                 wait_done();
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, due); wait_done();

        mt(1, 0, 32'h1234);
        mt(0, 1, 32'h5678);
        issue(OP_DIVU, 32'd5, 32'd0, 0, 0, 0, due);                  wait_done();
        mt(1, 1, 32'hCAFE_F00D);
        issue(OP_DIV, 32'd9, 32'd0, 1, 1, 32'h0BAD_0BAD, due);       wait_done();

        // Start and MT writes during a running MULT must be ignored.
        issue(OP_MULT, 32'h1234_5678, -32'd99, 0, 0, 0, due);
        repeat (9) next_cycle();
        start = 1'b1; op = OP_DIVU; inp_a = 32'd100; inp_b = 32'd3;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
        next_cycle();
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        wait_done();

        // Back-to-back: second start lands in the first op's done cycle.
        issue(OP_MULTU, 32'd1000, 32'd1000, 0, 0, 0, due);
        while (cyc < due) next_cycle();
        issue(OP_DIV, -32'd100, 32'd7, 0, 0, 0, due);
        wait_done();

        // Reset in cycle 12 of a DIV aborts it with no done.
        issue(OP_DIV, 32'd1_000_000, 32'd3, 0, 0, 0, due);
        repeat (11) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        repeat (40) next_cycle();
        issue(OP_MULTU, 32'd3, 32'd5, 0, 0, 0, due); wait_done();

        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 3) == 0)
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            ra = rnd32();
            rb = ($urandom_range(0, 9) == 0) ? 32'd0 : rnd32();
            issue(2'($urandom_range(0, 3)), ra, rb,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), $urandom, due);
            wait_done();
        end

        repeat (2) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
